// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared constants and state type for the 4x4 matmul front end
package matmul_pkg;

    localparam int N     = 4;
    localparam int ELEMS = 2 * N * N;

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } ld_state_t;

endpackage

// File: rtl/matrix_operand_loader_4x4.sv
// rtl/matrix_operand_loader_4x4.sv - assembles serial A/B elements into parallel 4x4 operands
module matrix_operand_loader_4x4
    import matmul_pkg::*;
#(
    parameter int w = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [w-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic signed [w-1:0] A_o [0:N-1][0:N-1],
    output logic signed [w-1:0] B_o [0:N-1][0:N-1],
    output logic                out_valid,
    input  logic                out_ready,
    output logic                frame_err,
    output logic [7:0]          err_cnt
);

    ld_state_t  state_q;
    ld_state_t  state_d;
    logic [4:0] cnt_q;
    logic [4:0] cnt_d;
    logic       in_ready_d;
    logic       out_valid_d;
    logic       wr_en;
    logic       bad_frame;
    logic       accept;
    logic       at_end;

    assign accept = in_valid && in_ready;
    assign at_end = (cnt_q == 5'(ELEMS - 1));

    // A frame is well formed only when in_last coincides exactly with the 32nd element.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        bad_frame = 1'b0;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (at_end && in_last) begin
                        wr_en   = 1'b1;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else if (at_end || in_last) begin
                        bad_frame = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        in_ready_d  = (state_d == LOAD);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // cnt[4] selects the matrix, cnt[3:2] the row and cnt[1:0] the column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    A_o[r][c] <= '0;
                    B_o[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            if (!cnt_q[4]) begin
                A_o[cnt_q[3:2]][cnt_q[1:0]] <= in_data;
            end else begin
                B_o[cnt_q[3:2]][cnt_q[1:0]] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            frame_err <= bad_frame;
            if (bad_frame && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
